// File: rtl/spi_cs_arbiter.sv
// ============================================================================
//  Module   : spi_cs_arbiter
//  Purpose  : Round-robin sharing of one SPI_Master byte engine between
//             NUM_REQ clients, with one active-low chip select per client.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_cs_arbiter #(
    parameter int NUM_REQ          = 2,
    parameter int CS_SETUP_CLKS    = 2,
    parameter int CS_INACTIVE_CLKS = 4
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic [NUM_REQ-1:0]     i_Req,
    input  logic [8*NUM_REQ-1:0]   i_Req_Count,
    input  logic [8*NUM_REQ-1:0]   i_Req_TX_Byte,
    input  logic [NUM_REQ-1:0]     i_Req_TX_DV,
    output logic [NUM_REQ-1:0]     o_Req_TX_Ready,
    output logic [NUM_REQ-1:0]     o_Req_Grant,
    output logic [NUM_REQ-1:0]     o_Req_RX_DV,
    output logic [7:0]             o_Req_RX_Byte,
    output logic [NUM_REQ-1:0]     o_Req_Done,
    output logic [7:0]             o_M_TX_Byte,
    output logic                   o_M_TX_DV,
    input  logic                   i_M_TX_Ready,
    input  logic                   i_M_RX_DV,
    input  logic [7:0]             i_M_RX_Byte,
    output logic [NUM_REQ-1:0]     o_SPI_CS_n
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int TMAX = (CS_SETUP_CLKS > CS_INACTIVE_CLKS) ? CS_SETUP_CLKS : CS_INACTIVE_CLKS;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CS_SETUP  = 3'd1;
    localparam logic [2:0] S_WAIT_BYTE = 3'd2;
    localparam logic [2:0] S_WAIT_RX   = 3'd3;
    localparam logic [2:0] S_CS_HOLD   = 3'd4;
    localparam logic [2:0] S_CS_GAP    = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     gidx_q, gidx_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] cs_n_q, cs_n_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic [NUM_REQ-1:0] rx_dv_q, rx_dv_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [7:0]         rx_byte_q, rx_byte_d;
    logic [7:0]         m_byte_q, m_byte_d;
    logic               m_dv_q, m_dv_d;

    logic [IDW-1:0]     win;
    logic               win_vld;
    logic [NUM_REQ-1:0] win_oh;
    logic [7:0]         win_cnt;
    logic               accept;
    logic [IDW:0]       scan;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        scan    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, ptr_q} + (IDW+1)'(i);
            if (scan >= (IDW+1)'(NUM_REQ)) begin
                scan = scan - (IDW+1)'(NUM_REQ);
            end
            if (!win_vld && i_Req[scan[IDW-1:0]]) begin
                win     = scan[IDW-1:0];
                win_vld = 1'b1;
            end
        end
    end

    assign win_oh  = NUM_REQ'(1) << win;
    assign win_cnt = i_Req_Count[{win, 3'b000} +: 8];
    assign accept  = (state_q == S_WAIT_BYTE) && |(ready_q & i_Req_TX_DV);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tmr_q     <= '0;
            ptr_q     <= '0;
            gidx_q    <= '0;
            grant_q   <= '0;
            cs_n_q    <= '1;
            ready_q   <= '0;
            rx_dv_q   <= '0;
            done_q    <= '0;
            rx_byte_q <= '0;
            m_byte_q  <= '0;
            m_dv_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            grant_q   <= grant_d;
            cs_n_q    <= cs_n_d;
            ready_q   <= ready_d;
            rx_dv_q   <= rx_dv_d;
            done_q    <= done_d;
            rx_byte_q <= rx_byte_d;
            m_byte_q  <= m_byte_d;
            m_dv_q    <= m_dv_d;
        end
    end

    // A grant still held in IDLE marks a zero-length transaction being retired.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        case (state_q)
            S_IDLE: begin
                if (grant_q == '0 && win_vld) begin
                    gidx_d = win;
                    ptr_d  = (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    cnt_d  = win_cnt;
                    if (win_cnt != 8'd0) begin
                        state_d = S_CS_SETUP;
                        tmr_d   = TW'(CS_SETUP_CLKS - 1);
                    end
                end
            end
            S_CS_SETUP: begin
                if (tmr_q == '0) state_d = S_WAIT_BYTE;
                else             tmr_d   = tmr_q - 1'b1;
            end
            S_WAIT_BYTE: begin
                if (accept) state_d = S_WAIT_RX;
            end
            S_WAIT_RX: begin
                if (i_M_RX_DV) begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == 8'd1) ? S_CS_HOLD : S_WAIT_BYTE;
                end
            end
            S_CS_HOLD: begin
                if (i_M_TX_Ready) begin
                    state_d = S_CS_GAP;
                    tmr_d   = TW'(CS_INACTIVE_CLKS - 1);
                end
            end
            S_CS_GAP: begin
                if (tmr_q == '0) state_d = S_IDLE;
                else             tmr_d   = tmr_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d   = grant_q;
        cs_n_d    = cs_n_q;
        ready_d   = '0;
        rx_dv_d   = '0;
        done_d    = '0;
        rx_byte_d = rx_byte_q;
        m_byte_d  = m_byte_q;
        m_dv_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_q != '0) begin
                    grant_d = '0;
                    done_d  = grant_q;
                end else if (win_vld) begin
                    grant_d = win_oh;
                    if (win_cnt != 8'd0) cs_n_d = ~win_oh;
                end
            end
            S_WAIT_BYTE: begin
                if (accept) begin
                    m_dv_d   = 1'b1;
                    m_byte_d = i_Req_TX_Byte[{gidx_q, 3'b000} +: 8];
                end
            end
            S_WAIT_RX: begin
                if (i_M_RX_DV) begin
                    rx_dv_d   = grant_q;
                    rx_byte_d = i_M_RX_Byte;
                end
            end
            S_CS_HOLD: begin
                if (i_M_TX_Ready) begin
                    cs_n_d  = '1;
                    grant_d = '0;
                    done_d  = grant_q;
                end
            end
            default: ;
        endcase
        if (state_d == S_WAIT_BYTE && i_M_TX_Ready) ready_d = grant_q;
    end

    assign o_Req_TX_Ready = ready_q;
    assign o_Req_Grant    = grant_q;
    assign o_Req_RX_DV    = rx_dv_q;
    assign o_Req_RX_Byte  = rx_byte_q;
    assign o_Req_Done     = done_q;
    assign o_M_TX_Byte    = m_byte_q;
    assign o_M_TX_DV      = m_dv_q;
    assign o_SPI_CS_n     = cs_n_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_cs_arbiter.sv
// ============================================================================
//  Module   : tb_spi_cs_arbiter
//  Purpose  : Directed self-checking bench for spi_cs_arbiter with a
//             loopback SPI_Master byte-engine model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_cs_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [15:0] req_count = '0;
    logic [15:0] tx_byte = '0;
    logic [1:0]  auto_dv = '0;
    logic [1:0]  inj_dv = '0;
    logic [1:0]  tx_ready, grant, rx_dv, done, cs_n;
    logic [7:0]  rx_byte, m_tx_byte;
    logic        m_tx_dv;
    logic        m_tx_ready = 1'b1;
    logic        m_rx_dv = 1'b0;
    logic [7:0]  m_rx_byte = '0;

    spi_cs_arbiter #(.NUM_REQ(2), .CS_SETUP_CLKS(2), .CS_INACTIVE_CLKS(4)) dut (
        .i_Clk          (clk),
        .i_Rst_L        (rst_n),
        .i_Req          (req),
        .i_Req_Count    (req_count),
        .i_Req_TX_Byte  (tx_byte),
        .i_Req_TX_DV    (auto_dv | inj_dv),
        .o_Req_TX_Ready (tx_ready),
        .o_Req_Grant    (grant),
        .o_Req_RX_DV    (rx_dv),
        .o_Req_RX_Byte  (rx_byte),
        .o_Req_Done     (done),
        .o_M_TX_Byte    (m_tx_byte),
        .o_M_TX_DV      (m_tx_dv),
        .i_M_TX_Ready   (m_tx_ready),
        .i_M_RX_DV      (m_rx_dv),
        .i_M_RX_Byte    (m_rx_byte),
        .o_SPI_CS_n     (cs_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte-engine model: MOSI looped to MISO, RX two cycles before ready returns.
    int         m_busy = 0;
    logic [7:0] m_shift = '0;
    always @(negedge clk) begin
        m_rx_dv = 1'b0;
        if (!rst_n) begin
            m_busy     = 0;
            m_tx_ready = 1'b1;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 2) begin
                m_rx_dv   = 1'b1;
                m_rx_byte = m_shift;
            end
            if (m_busy == 0) m_tx_ready = 1'b1;
        end else if (m_tx_dv) begin
            m_tx_ready = 1'b0;
            m_shift    = m_tx_byte;
            m_busy     = 6;
        end
    end

    // Well-behaved clients: present the next queued byte whenever ready.
    logic [7:0] tx_data [2][64];
    int         tx_idx [2] = '{0, 0};
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            auto_dv[k] = 1'b0;
            if (tx_ready[k]) begin
                auto_dv[k]          = 1'b1;
                tx_byte[8*k +: 8]   = tx_data[k][tx_idx[k] % 64];
                tx_idx[k]++;
            end
        end
    end

    // Monitor: event counters and logs, all sampled on the falling edge.
    int         mtx_cnt = 0;
    int         done_cnt [2] = '{0, 0};
    int         cs_fall [2] = '{0, 0};
    int         rx_n = 0;
    logic [7:0] rx_log [256];
    int         rx_who [256];
    int         ord_n = 0;
    int         ord_log [256];
    int         gap_run = 0;
    int         last_gap = 0;
    int         onehot_viol = 0;
    logic [1:0] prev_cs = 2'b11;
    logic [1:0] prev_grant = 2'b00;
    always @(negedge clk) begin
        if (m_tx_dv) mtx_cnt++;
        if ($countones(grant) > 1 || $countones(~cs_n) > 1) onehot_viol++;
        for (int k = 0; k < 2; k++) begin
            if (done[k]) done_cnt[k]++;
            if (rx_dv[k]) begin
                rx_log[rx_n % 256] = rx_byte;
                rx_who[rx_n % 256] = k;
                rx_n++;
            end
            if (grant[k] && !prev_grant[k]) begin
                ord_log[ord_n % 256] = k;
                ord_n++;
            end
            if (prev_cs[k] && !cs_n[k]) begin
                cs_fall[k]++;
                last_gap = gap_run;
            end
            if (!prev_cs[k] && cs_n[k]) gap_run = 0;
        end
        if (&cs_n) gap_run++;
        prev_cs    = cs_n;
        prev_grant = grant;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        tx_data[k][(tx_idx[k] + 0) % 64] = b0;
        tx_data[k][(tx_idx[k] + 1) % 64] = b1;
        tx_data[k][(tx_idx[k] + 2) % 64] = b2;
    endtask

    task automatic wait_grant(input int k, input string tag);
        int n = 0;
        while (!grant[k] && n < 300) begin
            tick();
            n++;
        end
        check(tag, grant[k], 1'b1);
    endtask

    task automatic wait_done(input int k, input int target, input string tag);
        int n = 0;
        while (done_cnt[k] < target && n < 600) begin
            tick();
            n++;
        end
        check(tag, done_cnt[k] >= target, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    int b_mtx, b_rx, b_ord, b_d0, b_d1, b_f0, b_f1;

    task automatic snap();
        b_mtx = mtx_cnt; b_rx = rx_n; b_ord = ord_n;
        b_d0 = done_cnt[0]; b_d1 = done_cnt[1];
        b_f0 = cs_fall[0]; b_f1 = cs_fall[1];
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_cs_n", cs_n, 2'b11);
        check("rst_grant", grant, 2'b00);
        check("rst_m_dv", m_tx_dv, 1'b0);
        check("rst_ready", tx_ready, 2'b00);
        check("rst_done", done, 2'b00);
        rst_n = 1'b1;
        repeat (2) tick();

        // Three-byte transaction on requester 0
        snap();
        load(0, 8'hC1, 8'hBE, 8'hEF);
        req_count = {8'd0, 8'd3};
        req = 2'b01;
        wait_grant(0, "t1_grant");
        req = 2'b00;
        wait_done(0, b_d0 + 1, "t1_done_seen");
        check("t1_cs_released_with_done", cs_n, 2'b11);
        check("t1_grant_cleared", grant, 2'b00);
        repeat (8) tick();
        check("t1_rx_count", rx_n - b_rx, 3);
        check("t1_rx0", rx_log[b_rx % 256], 8'hC1);
        check("t1_rx1", rx_log[(b_rx + 1) % 256], 8'hBE);
        check("t1_rx2", rx_log[(b_rx + 2) % 256], 8'hEF);
        check("t1_rx_owner", rx_who[(b_rx + 2) % 256], 0);
        check("t1_done_count", done_cnt[0] - b_d0, 1);
        check("t1_m_bytes", mtx_cnt - b_mtx, 3);
        check("t1_cs0_falls", cs_fall[0] - b_f0, 1);
        check("t1_cs1_quiet", cs_fall[1] - b_f1, 0);

        // Simultaneous requests right after reset
        do_reset();
        snap();
        load(0, 8'h5A, 8'h00, 8'h00);
        load(1, 8'h11, 8'h22, 8'h00);
        req_count = {8'd2, 8'd1};
        req = 2'b11;
        wait_grant(0, "t2_grant0");
        req = 2'b10;
        wait_grant(1, "t2_grant1");
        req = 2'b00;
        wait_done(1, b_d1 + 1, "t2_done1");
        repeat (8) tick();
        check("t2_order0", ord_log[b_ord % 256], 0);
        check("t2_order1", ord_log[(b_ord + 1) % 256], 1);
        check("t2_gap_ge_inactive", last_gap >= 4, 1'b1);
        check("t2_rx_a", rx_log[b_rx % 256], 8'h5A);
        check("t2_rx_b_owner", rx_who[(b_rx + 1) % 256], 1);
        check("t2_rx_c", rx_log[(b_rx + 2) % 256], 8'h22);
        check("t2_m_bytes", mtx_cnt - b_mtx, 3);

        // Both held continuously: round-robin alternation
        do_reset();
        snap();
        for (int i = 0; i < 3; i++) begin
            load(0, 8'(8'h30 + i), 8'h00, 8'h00);
        end
        tx_data[0][(tx_idx[0] + 0) % 64] = 8'h30;
        tx_data[0][(tx_idx[0] + 1) % 64] = 8'h31;
        tx_data[0][(tx_idx[0] + 2) % 64] = 8'h32;
        load(1, 8'h40, 8'h41, 8'h42);
        req_count = {8'd1, 8'd1};
        req = 2'b11;
        begin
            int n = 0;
            while (ord_n - b_ord < 6 && n < 400) begin
                tick();
                n++;
            end
        end
        req = 2'b00;
        check("t3_six_grants", ord_n - b_ord, 6);
        wait_done(1, b_d1 + 3, "t3_done1");
        repeat (8) tick();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3_order%0d", i), ord_log[(b_ord + i) % 256], i % 2);
        end
        check("t3_done0_count", done_cnt[0] - b_d0, 3);
        check("t3_rx_last", rx_log[(b_rx + 5) % 256], 8'h42);

        // Zero-length request
        snap();
        req_count = {8'd0, 8'd0};
        req = 2'b10;
        wait_grant(1, "t4_grant");
        req = 2'b00;
        wait_done(1, b_d1 + 1, "t4_done");
        check("t4_grant_dropped", grant, 2'b00);
        repeat (4) tick();
        check("t4_no_cs1", cs_fall[1] - b_f1, 0);
        check("t4_no_m_dv", mtx_cnt - b_mtx, 0);
        check("t4_done_once", done_cnt[1] - b_d1, 1);

        // Stray TX_DV from the other requester and while not ready
        snap();
        load(0, 8'hA5, 8'h96, 8'h00);
        req_count = {8'd0, 8'd2};
        req = 2'b01;
        wait_grant(0, "t5_grant");
        req = 2'b00;
        check("t5_not_ready_in_setup", tx_ready[0], 1'b0);
        inj_dv = 2'b11;
        tick();
        inj_dv = 2'b00;
        begin
            int n = 0;
            while (mtx_cnt == b_mtx && n < 100) begin
                tick();
                n++;
            end
        end
        tick();
        check("t5_ready_low_in_rx", tx_ready, 2'b00);
        inj_dv = 2'b11;
        tick();
        inj_dv = 2'b00;
        wait_done(0, b_d0 + 1, "t5_done");
        repeat (8) tick();
        check("t5_m_bytes", mtx_cnt - b_mtx, 2);
        check("t5_rx0", rx_log[b_rx % 256], 8'hA5);
        check("t5_rx1", rx_log[(b_rx + 1) % 256], 8'h96);

        // Asynchronous reset during the second byte
        snap();
        load(0, 8'h01, 8'h02, 8'h03);
        req_count = {8'd0, 8'd3};
        req = 2'b01;
        wait_grant(0, "t6_grant");
        req = 2'b00;
        begin
            int n = 0;
            while (mtx_cnt - b_mtx < 2 && n < 200) begin
                tick();
                n++;
            end
        end
        check("t6_second_byte_sent", mtx_cnt - b_mtx, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_cs_async_release", cs_n, 2'b11);
        check("t6_grant_async_clear", grant, 2'b00);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("t6_no_done", done_cnt[0] - b_d0, 0);
        snap();
        load(1, 8'h77, 8'h00, 8'h00);
        req_count = {8'd1, 8'd0};
        req = 2'b10;
        wait_grant(1, "t6_post_grant");
        req = 2'b00;
        wait_done(1, b_d1 + 1, "t6_post_done");
        check("t6_post_rx", rx_log[b_rx % 256], 8'h77);
        check("t6_post_m_bytes", mtx_cnt - b_mtx, 1);

        check("onehot_invariant", onehot_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
